// File: rtl/draw_board_cells.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : draw_board_cells                                           |
// | Description : Pixel-pipeline stage that follows the grid-drawing stage.  |
// |               Keeps the 12x12 board state in a 144-entry cell memory and |
// |               paints each cell interior with its state colour. Grid      |
// |               lines and off-board pixels pass through unchanged. Adds    |
// |               two cycles of latency to the pixel stream.                 |
// | Ports       : clk, rst            pixel clock, sync active-high reset    |
// |               in_*                incoming pixel stream (vga fields)     |
// |               out_*               outgoing pixel stream, 2 cycles later  |
// |               wr_en/wr_x/wr_y/    single-cell write from game logic      |
// |               wr_state            (00 empty, 01 ship, 10 hit, 11 miss)   |
// |               clr                 start a full-board clear sweep         |
// |               busy                clear sweep running, writes dropped    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module draw_board_cells #(
  parameter int X_POS     = 0,
  parameter int Y_POS     = 0,
  parameter int CELL_SIZE = 32,
  parameter int BORDER_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] in_vcount,
  input  logic        in_vsync,
  input  logic        in_vblnk,
  input  logic [10:0] in_hcount,
  input  logic        in_hsync,
  input  logic        in_hblnk,
  input  logic [11:0] in_rgb,
  output logic [10:0] out_vcount,
  output logic        out_vsync,
  output logic        out_vblnk,
  output logic [10:0] out_hcount,
  output logic        out_hsync,
  output logic        out_hblnk,
  output logic [11:0] out_rgb,
  input  logic        wr_en,
  input  logic [3:0]  wr_x,
  input  logic [3:0]  wr_y,
  input  logic [1:0]  wr_state,
  input  logic        clr,
  output logic        busy
);

  localparam int          c_LOG2  = $clog2(CELL_SIZE);
  localparam logic [10:0] c_BOARD = 11'(12 * CELL_SIZE);
  localparam logic [10:0] c_X     = 11'(X_POS);
  localparam logic [10:0] c_Y     = 11'(Y_POS);
  localparam logic [10:0] c_MASK  = 11'(CELL_SIZE - 1);
  localparam logic [10:0] c_BW    = 11'(BORDER_W);
  localparam logic [7:0]  c_LAST  = 8'd143;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_addr;
  logic [7:0]  w_next_addr;
  logic        r_busy;

  logic [1:0]  r_mem [0:143];
  logic        w_wr_in_range;
  logic [7:0]  w_wr_addr;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [1:0]  w_mem_data;

  // ---------------- clear-sweep FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_addr  <= 8'd0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_addr  <= w_next_addr;
      r_busy  <= (w_next_state == ST_CLEAR);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_addr  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (clr) begin
          w_next_state = ST_CLEAR;
          w_next_addr  = 8'd0;
        end
      end
      ST_CLEAR: begin
        if (clr) begin
          w_next_addr = 8'd0;          // restart the sweep from the top
        end else if (r_addr == c_LAST) begin
          w_next_state = ST_IDLE;
          w_next_addr  = 8'd0;
        end else begin
          w_next_addr = r_addr + 8'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_addr  = 8'd0;
      end
    endcase
  end

  assign busy = r_busy;

  // ---------------- cell memory write port ----------------
  assign w_wr_in_range = (wr_x < 4'd12) && (wr_y < 4'd12);
  assign w_wr_addr     = ({4'd0, wr_y} * 8'd12) + {4'd0, wr_x};

  // The sweep owns the write port while clearing; a clr in IDLE beats a
  // simultaneous game write.
  assign w_mem_we   = !rst && ((r_state == ST_CLEAR) ||
                               (wr_en && w_wr_in_range && !clr));
  assign w_mem_addr = (r_state == ST_CLEAR) ? r_addr : w_wr_addr;
  assign w_mem_data = (r_state == ST_CLEAR) ? 2'b00 : wr_state;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // ---------------- pixel address decode ----------------
  logic [10:0] w_hrel;
  logic [10:0] w_vrel;
  logic [10:0] w_col;
  logic [10:0] w_row;
  logic [10:0] w_cell_full;
  logic        w_inside;
  logic        w_border;
  logic [7:0]  w_rd_addr;
  logic        w_unused;

  // Offsets wrap in 11 bits, so pixels left of / above the board become
  // large values and fail the inside test rather than aliasing into a cell.
  assign w_hrel      = in_hcount - c_X;
  assign w_vrel      = in_vcount - c_Y;
  assign w_inside    = (w_hrel < c_BOARD) && (w_vrel < c_BOARD);
  assign w_border    = ((w_hrel & c_MASK) < c_BW) || ((w_vrel & c_MASK) < c_BW);
  assign w_col       = w_hrel >> c_LOG2;
  assign w_row       = w_vrel >> c_LOG2;
  assign w_cell_full = (w_row * 11'd12) + w_col;
  assign w_rd_addr   = w_inside ? w_cell_full[7:0] : 8'd0;
  assign w_unused    = ^w_cell_full[10:8];

  // ---------------- stage 1 ----------------
  logic [1:0]  r_rd_state;
  logic [10:0] r_s1_vcount;
  logic [10:0] r_s1_hcount;
  logic        r_s1_vsync;
  logic        r_s1_vblnk;
  logic        r_s1_hsync;
  logic        r_s1_hblnk;
  logic [11:0] r_s1_rgb;
  logic        r_s1_inside;
  logic        r_s1_border;
  logic        r_s1_blank;

  // Separate read process: a same-edge write is not visible until later.
  always_ff @(posedge clk) begin
    r_rd_state <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vcount <= 11'd0;
      r_s1_hcount <= 11'd0;
      r_s1_vsync  <= 1'b0;
      r_s1_vblnk  <= 1'b0;
      r_s1_hsync  <= 1'b0;
      r_s1_hblnk  <= 1'b0;
      r_s1_rgb    <= 12'h000;
      r_s1_inside <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_blank  <= 1'b0;
    end else begin
      r_s1_vcount <= in_vcount;
      r_s1_hcount <= in_hcount;
      r_s1_vsync  <= in_vsync;
      r_s1_vblnk  <= in_vblnk;
      r_s1_hsync  <= in_hsync;
      r_s1_hblnk  <= in_hblnk;
      r_s1_rgb    <= in_rgb;
      r_s1_inside <= w_inside;
      r_s1_border <= w_border;
      r_s1_blank  <= in_vblnk | in_hblnk;
    end
  end

  // ---------------- stage 2 ----------------
  logic [11:0] w_rgb;

  always_comb begin
    w_rgb = r_s1_rgb;
    if (r_s1_blank) begin
      w_rgb = 12'h000;
    end else if (r_s1_inside && !r_s1_border) begin
      case (r_rd_state)
        2'b01:   w_rgb = 12'h888;
        2'b10:   w_rgb = 12'hF00;
        2'b11:   w_rgb = 12'h00F;
        default: w_rgb = r_s1_rgb;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vcount <= 11'd0;
      out_hcount <= 11'd0;
      out_vsync  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_hsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_rgb    <= 12'h000;
    end else begin
      out_vcount <= r_s1_vcount;
      out_hcount <= r_s1_hcount;
      out_vsync  <= r_s1_vsync;
      out_vblnk  <= r_s1_vblnk;
      out_hsync  <= r_s1_hsync;
      out_hblnk  <= r_s1_hblnk;
      out_rgb    <= w_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_board_cells.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_draw_board_cells                                        |
// | Description : Directed self-checking bench for draw_board_cells. Two     |
// |               instances share all inputs: u_dut0 at board origin (0,0),  |
// |               u_dut1 at origin (100,50).                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_draw_board_cells;

  logic        clk;
  logic        rst;
  logic [10:0] in_vcount;
  logic        in_vsync;
  logic        in_vblnk;
  logic [10:0] in_hcount;
  logic        in_hsync;
  logic        in_hblnk;
  logic [11:0] in_rgb;
  logic        wr_en;
  logic [3:0]  wr_x;
  logic [3:0]  wr_y;
  logic [1:0]  wr_state;
  logic        clr;

  logic [10:0] o0_vcount, o1_vcount;
  logic        o0_vsync,  o1_vsync;
  logic        o0_vblnk,  o1_vblnk;
  logic [10:0] o0_hcount, o1_hcount;
  logic        o0_hsync,  o1_hsync;
  logic        o0_hblnk,  o1_hblnk;
  logic [11:0] o0_rgb,    o1_rgb;
  logic        busy0,     busy1;

  int n_cmp = 0;
  int n_err = 0;

  draw_board_cells u_dut0 (
    .clk(clk), .rst(rst),
    .in_vcount(in_vcount), .in_vsync(in_vsync), .in_vblnk(in_vblnk),
    .in_hcount(in_hcount), .in_hsync(in_hsync), .in_hblnk(in_hblnk),
    .in_rgb(in_rgb),
    .out_vcount(o0_vcount), .out_vsync(o0_vsync), .out_vblnk(o0_vblnk),
    .out_hcount(o0_hcount), .out_hsync(o0_hsync), .out_hblnk(o0_hblnk),
    .out_rgb(o0_rgb),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_state(wr_state),
    .clr(clr), .busy(busy0)
  );

  draw_board_cells #(.X_POS(100), .Y_POS(50)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_vcount(in_vcount), .in_vsync(in_vsync), .in_vblnk(in_vblnk),
    .in_hcount(in_hcount), .in_hsync(in_hsync), .in_hblnk(in_hblnk),
    .in_rgb(in_rgb),
    .out_vcount(o1_vcount), .out_vsync(o1_vsync), .out_vblnk(o1_vblnk),
    .out_hcount(o1_hcount), .out_hsync(o1_hsync), .out_hblnk(o1_hblnk),
    .out_rgb(o1_rgb),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_state(wr_state),
    .clr(clr), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one pixel and return once its result is on the outputs
  // (two clock edges later, sampled 1 time unit after the edge).
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                     input logic hb, input logic vb);
    in_hcount = h;
    in_vcount = v;
    in_rgb    = rgb;
    in_hblnk  = hb;
    in_vblnk  = vb;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wr_cell(input logic [3:0] x, input logic [3:0] y, input logic [1:0] s);
    wr_en    = 1'b1;
    wr_x     = x;
    wr_y     = y;
    wr_state = s;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
  endtask

  // Visit the centre of every cell on u_dut0; count cells whose output
  // differs from the input colour and cells showing colour col.
  task automatic scan(input logic [11:0] col, output int n_diff, output int n_col);
    n_diff = 0;
    n_col  = 0;
    for (int y = 0; y < 12; y++) begin
      for (int x = 0; x < 12; x++) begin
        pix(11'(x * 32 + 16), 11'(y * 32 + 16), 12'h5A5, 1'b0, 1'b0);
        if (o0_rgb != 12'h5A5) n_diff++;
        if (o0_rgb == col)     n_col++;
      end
    end
  endtask

  int cnt;
  int nd;
  int nc;

  initial begin
    rst = 1'b1;
    in_vcount = 11'd7; in_hcount = 11'd5; in_rgb = 12'hFFF;
    in_vsync = 1'b1; in_hsync = 1'b1; in_vblnk = 1'b0; in_hblnk = 1'b0;
    wr_en = 1'b0; wr_x = 4'd0; wr_y = 4'd0; wr_state = 2'b00; clr = 1'b0;

    // ---- 1. reset state and power-on sweep ----
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rgb",    {20'd0, o0_rgb},    32'h0);
    check_eq("rst_hcount", {21'd0, o0_hcount}, 32'h0);
    check_eq("rst_vcount", {21'd0, o0_vcount}, 32'h0);
    check_eq("rst_hsync",  {31'd0, o0_hsync},  32'h0);
    check_eq("rst_busy",   {31'd0, busy0},     32'h1);
    in_vsync = 1'b0; in_hsync = 1'b0;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy0) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("busy_after_reset_cycles", cnt, 144);
    check_eq("busy_dut1_idle", {31'd0, busy1}, 32'h0);
    scan(12'hFFF, nd, nc);
    check_eq("empty_board_painted", nd, 0);

    // ---- 2. hit cell colour and latency ----
    wr_cell(4'd3, 4'd2, 2'b10);
    pix(11'd0, 11'd0, 12'h111, 1'b0, 1'b0);
    in_hcount = 11'd106; in_vcount = 11'd74; in_rgb = 12'hABC;
    in_hsync = 1'b1; in_vsync = 1'b1;
    @(posedge clk);
    #1;
    check_eq("lat1_hcount_old", {21'd0, o0_hcount}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("hit_rgb",    {20'd0, o0_rgb},    32'hF00);
    check_eq("hit_hcount", {21'd0, o0_hcount}, 32'd106);
    check_eq("hit_vcount", {21'd0, o0_vcount}, 32'd74);
    check_eq("hit_hsync",  {31'd0, o0_hsync},  32'h1);
    check_eq("hit_vsync",  {31'd0, o0_vsync},  32'h1);
    in_hsync = 1'b0; in_vsync = 1'b0;

    // ---- 3. border, off-board, blanking, other colours ----
    pix(11'd97, 11'd74, 12'hABC, 1'b0, 1'b0);
    check_eq("border_pass", {20'd0, o0_rgb}, 32'hABC);
    pix(11'd106, 11'd65, 12'hABC, 1'b0, 1'b0);
    check_eq("border_v_pass", {20'd0, o0_rgb}, 32'hABC);
    pix(11'd384, 11'd74, 12'hABC, 1'b0, 1'b0);
    check_eq("offboard_h384", {20'd0, o0_rgb}, 32'hABC);
    pix(11'd106, 11'd74, 12'hABC, 1'b1, 1'b0);
    check_eq("hblnk_black", {20'd0, o0_rgb}, 32'h000);
    check_eq("hblnk_passed", {31'd0, o0_hblnk}, 32'h1);
    pix(11'd106, 11'd74, 12'hABC, 1'b0, 1'b1);
    check_eq("vblnk_black", {20'd0, o0_rgb}, 32'h000);
    wr_cell(4'd5, 4'd7, 2'b01);
    wr_cell(4'd11, 4'd11, 2'b11);
    pix(11'd180, 11'd240, 12'h123, 1'b0, 1'b0);
    check_eq("ship_rgb", {20'd0, o0_rgb}, 32'h888);
    pix(11'd372, 11'd372, 12'h123, 1'b0, 1'b0);
    check_eq("miss_corner_rgb", {20'd0, o0_rgb}, 32'h00F);
    wr_cell(4'd5, 4'd7, 2'b00);
    wr_cell(4'd11, 4'd11, 2'b00);
    wr_cell(4'd3, 4'd2, 2'b00);

    // ---- 4. out-of-range writes dropped ----
    wr_cell(4'd12, 4'd0, 2'b01);
    wr_cell(4'd0, 4'd15, 2'b01);
    wr_cell(4'd15, 4'd11, 2'b10);
    scan(12'h888, nd, nc);
    check_eq("oob_write_painted", nd, 0);

    // ---- 5. fill, clear, write during sweep, clr restart ----
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 12; x++)
        wr_cell(4'(x), 4'(y), 2'b01);
    scan(12'h888, nd, nc);
    check_eq("fill_ship_cells", nc, 144);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    // Sample k sits in sweep cycle k (address k) until the restart.
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy0) break;
      cnt++;
      if (k == 50) begin
        wr_en = 1'b1; wr_x = 4'd0; wr_y = 4'd0; wr_state = 2'b10;
      end
      if (k == 51) wr_en = 1'b0;
      if (k == 70) clr = 1'b1;
      if (k == 71) clr = 1'b0;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0; clr = 1'b0;
    // 70 cycles before the restart, the restart cycle, then a full 144.
    check_eq("busy_restart_cycles", cnt, 215);
    scan(12'hF00, nd, nc);
    check_eq("cleared_painted", nd, 0);
    check_eq("busy_write_dropped", nc, 0);

    // ---- 6. offset board on u_dut1 ----
    wr_cell(4'd0, 4'd0, 2'b11);
    pix(11'd99, 11'd60, 12'h3C3, 1'b0, 1'b0);
    check_eq("off_left_nowrap", {20'd0, o1_rgb}, 32'h3C3);
    pix(11'd110, 11'd49, 12'h3C3, 1'b0, 1'b0);
    check_eq("off_top_nowrap", {20'd0, o1_rgb}, 32'h3C3);
    pix(11'd100, 11'd52, 12'h3C3, 1'b0, 1'b0);
    check_eq("offset_edge_border", {20'd0, o1_rgb}, 32'h3C3);
    pix(11'd110, 11'd60, 12'h3C3, 1'b0, 1'b0);
    check_eq("offset_miss_rgb", {20'd0, o1_rgb}, 32'h00F);
    pix(11'd483, 11'd433, 12'h3C3, 1'b0, 1'b0);
    check_eq("offset_far_corner_empty", {20'd0, o1_rgb}, 32'h3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
